// File: rtl/i2c_slave_fifo_if.sv
// Purpose: groups the slave-engine and host strobes/data of the I2C slave byte FIFO pair.
// Latency: pure wiring, no storage.
// Backpressure: none here; full/empty qualifiers travel as ordinary signals.
interface i2c_slave_fifo_if #(
  parameter int AW = 4
);
  // slave engine side
  logic          si_rxff_wr;
  logic [7:0]    si_rxff_wdata;
  logic          si_rxff_full;
  logic          si_txff_rd;
  logic [7:0]    si_txff_rdata;
  logic          si_txff_empty;
  // host side
  logic          rx_rd;
  logic [7:0]    rx_rdata;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          tx_wr;
  logic [7:0]    tx_wdata;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic          flush_rx;
  logic          flush_tx;
  logic          clr_err;
  logic          rx_ovf;
  logic          rx_unf;
  logic          tx_ovf;
  logic          tx_unf;
  logic          rx_irq;

  // FIFO block view
  modport slave (
    input  si_rxff_wr, si_rxff_wdata, si_txff_rd, rx_rd, tx_wr, tx_wdata,
           flush_rx, flush_tx, clr_err,
    output si_rxff_full, si_txff_rdata, si_txff_empty, rx_rdata, rx_empty,
           rx_level, tx_full, tx_level, rx_ovf, rx_unf, tx_ovf, tx_unf, rx_irq
  );

  // driver view (slave engine plus host)
  modport master (
    output si_rxff_wr, si_rxff_wdata, si_txff_rd, rx_rd, tx_wr, tx_wdata,
           flush_rx, flush_tx, clr_err,
    input  si_rxff_full, si_txff_rdata, si_txff_empty, rx_rdata, rx_empty,
           rx_level, tx_full, tx_level, rx_ovf, rx_unf, tx_ovf, tx_unf, rx_irq
  );
endinterface

// File: rtl/i2c_slave_fifo.sv
// Purpose: dual FWFT byte FIFO (RX: slave->host, TX: host->slave) with sticky error flags and RX threshold irq.
// Latency: a pushed byte is visible at the head one clk later; full/empty/level update on the push/pop edge.
// Backpressure: push into a full FIFO is dropped (ovf) unless popped the same clk; pop from empty is ignored (unf).
module i2c_slave_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int RX_THRESH = 8
) (
  input logic            clk,
  input logic            rst,
  i2c_slave_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
  localparam logic [AW:0] THR_LVL  = (AW+1)'(RX_THRESH);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  // ---------------- RX FIFO (slave pushes, host pops) ----------------
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_lvl, rx_lvl_nxt;
  logic          rx_is_full, rx_is_empty;
  logic          rx_push_ok, rx_pop_ok, rx_ovf_evt, rx_unf_evt;
  logic          rx_ovf_q, rx_unf_q, rx_irq_q;

  assign rx_is_full  = (rx_lvl == FULL_LVL);
  assign rx_is_empty = (rx_lvl == '0);
  // A full FIFO still accepts a push when the same clk frees a slot.
  assign rx_push_ok  = bus.si_rxff_wr & ~bus.flush_rx & (~rx_is_full | bus.rx_rd);
  assign rx_pop_ok   = bus.rx_rd & ~bus.flush_rx & ~rx_is_empty;
  assign rx_ovf_evt  = bus.si_rxff_wr & ~bus.flush_rx & rx_is_full & ~bus.rx_rd;
  assign rx_unf_evt  = bus.rx_rd & ~bus.flush_rx & rx_is_empty;

  // Next RX occupancy; flush wins over any strobe.
  always_comb begin
    rx_lvl_nxt = rx_lvl;
    if (bus.flush_rx)              rx_lvl_nxt = '0;
    else if (rx_push_ok && !rx_pop_ok) rx_lvl_nxt = rx_lvl + ONE_LVL;
    else if (!rx_push_ok && rx_pop_ok) rx_lvl_nxt = rx_lvl - ONE_LVL;
  end

  // RX storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp] <= bus.si_rxff_wdata;
  end

  // RX pointers and level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
    end else begin
      rx_lvl <= rx_lvl_nxt;
      if (bus.flush_rx) begin
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (rx_push_ok) rx_wp <= rx_wp + ONE_PTR;
        if (rx_pop_ok)  rx_rp <= rx_rp + ONE_PTR;
      end
    end
  end

  // ---------------- TX FIFO (host pushes, slave pops) ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_lvl, tx_lvl_nxt;
  logic          tx_is_full, tx_is_empty;
  logic          tx_push_ok, tx_pop_ok, tx_ovf_evt, tx_unf_evt;
  logic          tx_ovf_q, tx_unf_q;

  assign tx_is_full  = (tx_lvl == FULL_LVL);
  assign tx_is_empty = (tx_lvl == '0);
  assign tx_push_ok  = bus.tx_wr & ~bus.flush_tx & (~tx_is_full | bus.si_txff_rd);
  assign tx_pop_ok   = bus.si_txff_rd & ~bus.flush_tx & ~tx_is_empty;
  assign tx_ovf_evt  = bus.tx_wr & ~bus.flush_tx & tx_is_full & ~bus.si_txff_rd;
  assign tx_unf_evt  = bus.si_txff_rd & ~bus.flush_tx & tx_is_empty;

  // Next TX occupancy; flush wins over any strobe.
  always_comb begin
    tx_lvl_nxt = tx_lvl;
    if (bus.flush_tx)              tx_lvl_nxt = '0;
    else if (tx_push_ok && !tx_pop_ok) tx_lvl_nxt = tx_lvl + ONE_LVL;
    else if (!tx_push_ok && tx_pop_ok) tx_lvl_nxt = tx_lvl - ONE_LVL;
  end

  // TX storage.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wp] <= bus.tx_wdata;
  end

  // TX pointers and level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else begin
      tx_lvl <= tx_lvl_nxt;
      if (bus.flush_tx) begin
        tx_wp <= '0;
        tx_rp <= '0;
      end else begin
        if (tx_push_ok) tx_wp <= tx_wp + ONE_PTR;
        if (tx_pop_ok)  tx_rp <= tx_rp + ONE_PTR;
      end
    end
  end

  // Sticky errors (a new event beats clr_err) and the registered RX threshold irq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
      rx_irq_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_evt | (rx_ovf_q & ~bus.clr_err);
      rx_unf_q <= rx_unf_evt | (rx_unf_q & ~bus.clr_err);
      tx_ovf_q <= tx_ovf_evt | (tx_ovf_q & ~bus.clr_err);
      tx_unf_q <= tx_unf_evt | (tx_unf_q & ~bus.clr_err);
      rx_irq_q <= (rx_lvl_nxt >= THR_LVL);
    end
  end

  // Outputs: heads are first-word-fall-through, forced to zero when empty.
  assign bus.rx_rdata      = rx_is_empty ? 8'h00 : rx_mem[rx_rp];
  assign bus.rx_empty      = rx_is_empty;
  assign bus.rx_level      = rx_lvl;
  assign bus.si_rxff_full  = rx_is_full;
  assign bus.si_txff_rdata = tx_is_empty ? 8'h00 : tx_mem[tx_rp];
  assign bus.si_txff_empty = tx_is_empty;
  assign bus.tx_full       = tx_is_full;
  assign bus.tx_level      = tx_lvl;
  assign bus.rx_ovf        = rx_ovf_q;
  assign bus.rx_unf        = rx_unf_q;
  assign bus.tx_ovf        = tx_ovf_q;
  assign bus.tx_unf        = tx_unf_q;
  assign bus.rx_irq        = rx_irq_q;

endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Purpose: self-checking bench for i2c_slave_fifo (vector table plus queue scoreboard sequences).
// Latency: checks sample 1 time unit after the rising edge that consumed the stimulus.
// Backpressure: exercises full/empty drop, same-clk push+pop, flush priority and async reset.
module tb_i2c_slave_fifo;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  i2c_slave_fifo_if #(.AW(4)) bus ();

  i2c_slave_fifo #(.DEPTH(16), .AW(4), .RX_THRESH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       srw;  logic [7:0] swd;
    logic       srd;  logic       hrd;
    logic       hw;   logic [7:0] hwd;
    logic       frx;  logic       ftx;  logic clr;
    logic [4:0] e_rxl; logic [4:0] e_txl;
    logic [7:0] e_rxd; logic [7:0] e_txd;
    logic [3:0] e_err;  // {rx_ovf, rx_unf, tx_ovf, tx_unf}
  } vec_t;

  vec_t vecs [12];
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.si_rxff_wr = 1'b0; bus.si_rxff_wdata = 8'h00; bus.si_txff_rd = 1'b0;
    bus.rx_rd = 1'b0; bus.tx_wr = 1'b0; bus.tx_wdata = 8'h00;
    bus.flush_rx = 1'b0; bus.flush_tx = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] errs();
    return {bus.rx_ovf, bus.rx_unf, bus.tx_ovf, bus.tx_unf};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rx_level"}, 32'(bus.rx_level), 0);
    chk({tag, "_tx_level"}, 32'(bus.tx_level), 0);
    chk({tag, "_rx_empty"}, 32'(bus.rx_empty), 1);
    chk({tag, "_tx_empty"}, 32'(bus.si_txff_empty), 1);
    chk({tag, "_rx_full"},  32'(bus.si_rxff_full), 0);
    chk({tag, "_tx_full"},  32'(bus.tx_full), 0);
    chk({tag, "_rx_rdata"}, 32'(bus.rx_rdata), 0);
    chk({tag, "_tx_rdata"}, 32'(bus.si_txff_rdata), 0);
    chk({tag, "_errs"},     32'(errs()), 0);
    chk({tag, "_rx_irq"},   32'(bus.rx_irq), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    idle();

    //            srw swd   srd hrd hw hwd   frx ftx clr  rxl txl rxd    txd    err
    vecs[0]  = '{1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hA5, 8'h00, 4'b0000};
    vecs[1]  = '{1, 8'h3C, 0, 0, 0, 8'h00, 0, 0, 0, 2, 0, 8'hA5, 8'h00, 4'b0000};
    vecs[2]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 8'h3C, 8'h00, 4'b0000};
    vecs[3]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000};
    vecs[4]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0100};
    vecs[5]  = '{0, 8'h00, 1, 0, 1, 8'h11, 0, 0, 0, 0, 1, 8'h00, 8'h11, 4'b0101};
    vecs[6]  = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 8'h11, 4'b0000};
    vecs[7]  = '{0, 8'h00, 1, 0, 1, 8'h22, 0, 0, 0, 0, 1, 8'h00, 8'h22, 4'b0000};
    vecs[8]  = '{1, 8'h77, 0, 1, 0, 8'h00, 0, 0, 1, 1, 1, 8'h77, 8'h22, 4'b0100};
    vecs[9]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h77, 8'h00, 4'b0000};
    vecs[10] = '{1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000};
    vecs[11] = '{0, 8'h00, 1, 0, 1, 8'h66, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'b0000};

    // Reset state while held in reset, then release away from the edge.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    step();

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      bus.si_rxff_wr = vecs[i].srw; bus.si_rxff_wdata = vecs[i].swd;
      bus.si_txff_rd = vecs[i].srd; bus.rx_rd = vecs[i].hrd;
      bus.tx_wr = vecs[i].hw; bus.tx_wdata = vecs[i].hwd;
      bus.flush_rx = vecs[i].frx; bus.flush_tx = vecs[i].ftx; bus.clr_err = vecs[i].clr;
      step();
      idle();
      chk($sformatf("v%0d_rx_level", i), 32'(bus.rx_level), 32'(vecs[i].e_rxl));
      chk($sformatf("v%0d_tx_level", i), 32'(bus.tx_level), 32'(vecs[i].e_txl));
      chk($sformatf("v%0d_rx_rdata", i), 32'(bus.rx_rdata), 32'(vecs[i].e_rxd));
      chk($sformatf("v%0d_tx_rdata", i), 32'(bus.si_txff_rdata), 32'(vecs[i].e_txd));
      chk($sformatf("v%0d_rx_empty", i), 32'(bus.rx_empty), 32'(vecs[i].e_rxl == 0));
      chk($sformatf("v%0d_tx_empty", i), 32'(bus.si_txff_empty), 32'(vecs[i].e_txl == 0));
      chk($sformatf("v%0d_errs", i), 32'(errs()), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_rx_irq", i), 32'(bus.rx_irq), 0);
    end

    // TX fill to full, overflow drop, drain through scoreboard.
    for (int i = 0; i < 16; i++) begin
      bus.tx_wr = 1'b1; bus.tx_wdata = 8'(i);
      tx_q.push_back(8'(i));
      step();
    end
    bus.tx_wr = 1'b0;
    chk("tx_full_at_16", 32'(bus.tx_full), 1);
    chk("tx_level_16", 32'(bus.tx_level), 16);
    chk("tx_ovf_before", 32'(bus.tx_ovf), 0);
    bus.tx_wr = 1'b1; bus.tx_wdata = 8'hFF;
    step();
    idle();
    chk("tx_ovf_after_drop", 32'(bus.tx_ovf), 1);
    chk("tx_level_after_drop", 32'(bus.tx_level), 16);
    for (int i = 0; i < 16 && tx_q.size() > 0; i++) begin
      chk($sformatf("tx_pop%0d", i), 32'(bus.si_txff_rdata), 32'(tx_q.pop_front()));
      bus.si_txff_rd = 1'b1;
      step();
      chk($sformatf("tx_level_pop%0d", i), 32'(bus.tx_level), 32'(tx_q.size()));
    end
    idle();
    chk("tx_empty_drained", 32'(bus.si_txff_empty), 1);
    chk("tx_rdata_drained", 32'(bus.si_txff_rdata), 0);

    // TX underflow, then clr_err clears it on the next clk.
    bus.si_txff_rd = 1'b1;
    step();
    idle();
    chk("tx_unf_set", 32'(bus.tx_unf), 1);
    chk("tx_rdata_unf", 32'(bus.si_txff_rdata), 0);
    bus.clr_err = 1'b1;
    step();
    idle();
    chk("tx_errs_cleared", 32'({bus.tx_ovf, bus.tx_unf}), 0);

    // RX fill with irq threshold tracking.
    for (int i = 0; i < 16; i++) begin
      bus.si_rxff_wr = 1'b1; bus.si_rxff_wdata = 8'h40 + 8'(i);
      rx_q.push_back(8'h40 + 8'(i));
      step();
      chk($sformatf("rx_level_push%0d", i), 32'(bus.rx_level), 32'(i + 1));
      chk($sformatf("rx_irq_push%0d", i), 32'(bus.rx_irq), 32'(i + 1 >= 8));
    end
    idle();
    chk("rx_full_at_16", 32'(bus.si_rxff_full), 1);

    // Full RX: push and pop in the same clk.
    chk("rx_head_before_pp", 32'(bus.rx_rdata), 32'(rx_q.pop_front()));
    bus.si_rxff_wr = 1'b1; bus.si_rxff_wdata = 8'hEE; bus.rx_rd = 1'b1;
    rx_q.push_back(8'hEE);
    step();
    idle();
    chk("rx_level_pp_full", 32'(bus.rx_level), 16);
    chk("rx_full_pp", 32'(bus.si_rxff_full), 1);
    chk("rx_ovf_pp", 32'(bus.rx_ovf), 0);
    chk("rx_head_after_pp", 32'(bus.rx_rdata), 32'(rx_q[0]));

    // Lone push into full RX is dropped.
    bus.si_rxff_wr = 1'b1; bus.si_rxff_wdata = 8'h99;
    step();
    idle();
    chk("rx_ovf_drop", 32'(bus.rx_ovf), 1);
    chk("rx_level_drop", 32'(bus.rx_level), 16);

    // Drain RX: order, tail byte and irq falling below threshold.
    for (int i = 0; i < 16 && rx_q.size() > 0; i++) begin
      chk($sformatf("rx_pop%0d", i), 32'(bus.rx_rdata), 32'(rx_q.pop_front()));
      bus.rx_rd = 1'b1;
      step();
      chk($sformatf("rx_level_pop%0d", i), 32'(bus.rx_level), 32'(rx_q.size()));
      chk($sformatf("rx_irq_pop%0d", i), 32'(bus.rx_irq), 32'(rx_q.size() >= 8));
    end
    idle();
    chk("rx_empty_drained", 32'(bus.rx_empty), 1);
    bus.clr_err = 1'b1;
    step();
    idle();
    chk("rx_ovf_cleared", 32'(bus.rx_ovf), 0);

    // flush_tx beats a tx_wr in the same clk at level 5.
    for (int i = 0; i < 5; i++) begin
      bus.tx_wr = 1'b1; bus.tx_wdata = 8'hB0 + 8'(i);
      step();
    end
    idle();
    chk("tx_level_5", 32'(bus.tx_level), 5);
    bus.flush_tx = 1'b1; bus.tx_wr = 1'b1; bus.tx_wdata = 8'hC7;
    step();
    idle();
    chk("flush_tx_level", 32'(bus.tx_level), 0);
    chk("flush_tx_empty", 32'(bus.si_txff_empty), 1);
    chk("flush_tx_no_ovf", 32'(bus.tx_ovf), 0);

    // Async reset mid-burst.
    bus.si_txff_rd = 1'b1;
    step();
    bus.si_txff_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.si_rxff_wr = 1'b1; bus.si_rxff_wdata = 8'hD0 + 8'(i);
      bus.tx_wr = 1'b1; bus.tx_wdata = 8'hE0 + 8'(i);
      step();
    end
    chk("burst_rx_level", 32'(bus.rx_level), 3);
    chk("burst_tx_unf", 32'(bus.tx_unf), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_rx_level", 32'(bus.rx_level), 0);
    chk("post_rst_tx_level", 32'(bus.tx_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
